psum_quant_pack: RTL and testbench
==================================

// Module: psum_quant_pack
// PURPOSE
//   Output stage directly downstream of the partial-sum buffer. Consumes the finished psum stream
//   (one signed DATA_W value per valid cycle), adds bias, applies optional ReLU, rounds/shifts and
//   saturates to signed OUT_W, packs PACK results per word and buffers words in an output FIFO
//   with a valid/ready interface toward the output write-back/DMA stage.
// PARAMETERS
//   DATA_W      25  width of incoming partial sums (signed)
//   OUT_W       8   width of each quantised result (signed)
//   PACK        4   results per output word; word width = PACK*OUT_W
//   FIFO_DEPTH  16  output word FIFO entries (power of two)
//   SHIFT_W     5   width of right-shift amount
// PORTS
//   clk         in   1              clock
//   rst_n       in   1              reset, asynchronous, active-low
//   cfg_bias    in   DATA_W         signed bias added to every psum
//   cfg_shift   in   SHIFT_W        arithmetic right shift amount (0..DATA_W)
//   cfg_relu    in   1              1 = clamp negative results to 0
//   clr_status  in   1              synchronous clear of overflow and sat_cnt
//   in_valid    in   1              psum valid (no backpressure: upstream never stalls)
//   in_data     in   DATA_W         signed psum
//   in_last     in   1              with in_valid: last psum of row; flushes partial word
//   out_valid   out  1              FIFO non-empty
//   out_ready   in   1              consumer accepts word when out_valid & out_ready
//   out_data    out  PACK*OUT_W     packed word, lane 0 at [OUT_W-1:0]
//   out_keep    out  PACK           lane-valid mask of out_data
//   out_last    out  1              word carries the row's last result
//   overflow    out  1              sticky: a word was dropped because FIFO was full
//   sat_cnt     out  16             count of saturated results, holds at 16'hFFFF
// BEHAVIOUR
//   Reset: out_valid/overflow/out_last=0, out_data/out_keep=0, sat_cnt=0, lane=0, FIFO empty,
//     pipeline valids cleared. Reset mid-row discards any partial word and all FIFO contents.
//   Config (cfg_*) sampled every cycle; changing it while data is in stages 1-2 is undefined
//     (controller changes it only between layers).
//   S1 (reg): sum = sext(in_data) + sext(cfg_bias), DATA_W+1 bits, no overflow possible.
//   S2 (reg): r = (sum + (cfg_shift? 1<<(cfg_shift-1) : 0)) >>> cfg_shift (round half up,
//     DATA_W+2 bit intermediate); if cfg_relu & r<0 -> 0; saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1];
//     sat_cnt += 1 when clamping changed value (ReLU clamp does not count).
//   Packer: lane counter 0..PACK-1; each S2 result written to lane, keep bit set.
//     Push word when lane==PACK-1 or result tagged last; then lane=0, keep cleared.
//     Last on lane PACK-1: single push with out_last=1 (no empty extra word).
//   Latency: input sampled at edge N -> word in FIFO at edge N+3 -> out_valid high cycle after N+3
//     when FIFO was empty (FWFT: out_data valid whenever out_valid).
//   FIFO: push & pop same cycle legal at any level incl. full (count unchanged, push accepted).
//     Push while full and no pop: word dropped, overflow<=1 (sticky until clr_status/reset).
//     out_valid never asserts on empty; pop with out_valid=0 ignored.
//   clr_status same cycle as a new overflow/saturation: set wins.
//   Back-to-back in_valid every cycle sustains 1 result/cycle; out_ready=1 drains 1 word/cycle.
// TESTING
//   bias=8, shift=4, relu=0, in=100 -> result 7 (0x07) in lane 0; 4 such -> out_data=0x07070707.
//   shift=0, in=-50: relu=0 -> lane 0xCE; relu=1 -> 0x00; sat_cnt stays 0.
//   shift=2, in=5000 -> 0x7F, sat_cnt=1; in=-5000 relu=0 -> 0x80, sat_cnt=2.
//   6 results, in_last on 6th -> word1 keep=4'hF last=0, word2 keep=4'h3 last=1.
//   out_ready=0, push 17 words -> 16 held, overflow=1; drain -> 16 words in order; clr_status -> 0.
//   Full FIFO with out_ready=1 and a push same cycle -> no drop, overflow stays 0; rst_n mid-row
//     -> out_valid=0 immediately, next row starts at lane 0.

Source files
------------

// File: rtl/psum_quant_pack.sv
// Output stage after the partial-sum buffer: bias, optional ReLU, round/shift,
// saturate to OUT_W, pack PACK results per word and buffer words in a FWFT FIFO.
module psum_quant_pack #(
  parameter int DATA_W     = 25,
  parameter int OUT_W      = 8,
  parameter int PACK       = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int SHIFT_W    = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     cfg_bias,
  input  logic [SHIFT_W-1:0]    cfg_shift,
  input  logic                  cfg_relu,
  input  logic                  clr_status,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PACK*OUT_W-1:0] out_data,
  output logic [PACK-1:0]       out_keep,
  output logic                  out_last,
  output logic                  overflow,
  output logic [15:0]           sat_cnt
);

  localparam int SUM_W  = DATA_W + 1;
  localparam int RND_W  = DATA_W + 2;
  localparam int WORD_W = PACK * OUT_W;
  localparam int ENT_W  = WORD_W + PACK + 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;

  localparam logic signed [RND_W-1:0] Q_MAX = RND_W'(2**(OUT_W-1) - 1);
  localparam logic signed [RND_W-1:0] Q_MIN = RND_W'(-(2**(OUT_W-1)));

  // Stage 1: bias add
  logic                    s1_valid_q, s1_last_q;
  logic signed [SUM_W-1:0] s1_sum_q, s1_sum_d;

  assign s1_sum_d = SUM_W'($signed(in_data)) + SUM_W'($signed(cfg_bias));

  // Stage 2: round half up, shift, ReLU, saturate
  logic signed [RND_W-1:0] rnd_add, rnd_sum, shifted, relu_val;
  logic [OUT_W-1:0]        q_d;
  logic                    sat_hit;
  logic                    s2_valid_q, s2_last_q;
  logic [OUT_W-1:0]        s2_res_q;

  always_comb begin
    rnd_add = '0;
    if (cfg_shift != '0) rnd_add = RND_W'(1) << (cfg_shift - SHIFT_W'(1));
    rnd_sum  = RND_W'(s1_sum_q) + rnd_add;
    shifted  = rnd_sum >>> cfg_shift;
    relu_val = (cfg_relu && shifted[RND_W-1]) ? '0 : shifted;
    sat_hit  = 1'b0;
    q_d      = relu_val[OUT_W-1:0];
    if (relu_val > Q_MAX) begin
      q_d     = Q_MAX[OUT_W-1:0];
      sat_hit = s1_valid_q;
    end else if (relu_val < Q_MIN) begin
      q_d     = Q_MIN[OUT_W-1:0];
      sat_hit = s1_valid_q;
    end
  end

  logic [15:0] sat_cnt_q, sat_cnt_d;

  // A saturation in the same cycle as clr_status survives the clear.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (clr_status) sat_cnt_d = '0;
    if (sat_hit && (sat_cnt_d != '1)) sat_cnt_d = sat_cnt_d + 16'd1;
  end

  // Packer
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [WORD_W-1:0] word_q, word_d, word_ins;
  logic [PACK-1:0]   keep_q, keep_d, keep_ins;
  logic              do_push;
  logic              push_q, push_last_q;
  logic [WORD_W-1:0] push_data_q;
  logic [PACK-1:0]   push_keep_q;

  always_comb begin
    word_ins = word_q;
    keep_ins = keep_q;
    word_ins[lane_q*OUT_W +: OUT_W] = s2_res_q;
    keep_ins[lane_q] = 1'b1;
    do_push = s2_valid_q && ((lane_q == LANE_W'(PACK-1)) || s2_last_q);
    lane_d  = lane_q;
    word_d  = word_q;
    keep_d  = keep_q;
    if (s2_valid_q) begin
      if (do_push) begin
        lane_d = '0;
        word_d = '0;
        keep_d = '0;
      end else begin
        lane_d = lane_q + LANE_W'(1);
        word_d = word_ins;
        keep_d = keep_ins;
      end
    end
  end

  // Output FIFO
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             full, empty, pop, wr_en, drop;
  logic             overflow_q;

  assign full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign empty = (cnt_q == '0);
  assign pop   = !empty && out_ready;
  assign wr_en = push_q && (!full || pop);
  assign drop  = push_q && full && !pop;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_en && !pop)      cnt_d = cnt_q + (AW+1)'(1);
    else if (!wr_en && pop) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_sum_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_res_q    <= '0;
      sat_cnt_q   <= '0;
      lane_q      <= '0;
      word_q      <= '0;
      keep_q      <= '0;
      push_q      <= 1'b0;
      push_last_q <= 1'b0;
      push_data_q <= '0;
      push_keep_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      overflow_q  <= 1'b0;
    end else begin
      s1_valid_q <= in_valid;
      s1_last_q  <= in_valid && in_last;
      if (in_valid) s1_sum_q <= s1_sum_d;
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_valid_q && s1_last_q;
      if (s1_valid_q) s2_res_q <= q_d;
      sat_cnt_q <= sat_cnt_d;
      lane_q    <= lane_d;
      word_q    <= word_d;
      keep_q    <= keep_d;
      push_q    <= do_push;
      if (do_push) begin
        push_data_q <= word_ins;
        push_keep_q <= keep_ins;
        push_last_q <= s2_last_q;
      end
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_d;
      if (drop)            overflow_q <= 1'b1;
      else if (clr_status) overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {push_last_q, push_keep_q, push_data_q};
  end

  assign out_valid = !empty;
  assign {out_last, out_keep, out_data} = out_valid ? mem_q[rd_ptr_q] : '0;
  assign overflow  = overflow_q;
  assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_psum_quant_pack.sv
// Bench for psum_quant_pack: directed cases plus randomized layers scored
// against an arithmetic reference model.
module tb_psum_quant_pack;
  localparam int DATA_W = 25, OUT_W = 8, PACK = 4, FIFO_DEPTH = 16, SHIFT_W = 5;

  logic                  clk, rst_n;
  logic [DATA_W-1:0]     cfg_bias;
  logic [SHIFT_W-1:0]    cfg_shift;
  logic                  cfg_relu, clr_status;
  logic                  in_valid, in_last;
  logic [DATA_W-1:0]     in_data;
  logic                  out_valid, out_ready, out_last, overflow;
  logic [PACK*OUT_W-1:0] out_data;
  logic [PACK-1:0]       out_keep;
  logic [15:0]           sat_cnt;

  psum_quant_pack #(.DATA_W(DATA_W), .OUT_W(OUT_W), .PACK(PACK),
                    .FIFO_DEPTH(FIFO_DEPTH), .SHIFT_W(SHIFT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_bias(cfg_bias), .cfg_shift(cfg_shift),
    .cfg_relu(cfg_relu), .clr_status(clr_status), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_keep(out_keep),
    .out_last(out_last), .overflow(overflow), .sat_cnt(sat_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct { logic [31:0] data; logic [3:0] keep; bit last; } word_t;
  word_t       exp_q[$];
  word_t       mon_w;
  logic [31:0] m_word;
  logic [3:0]  m_keep;
  int          m_lane, m_sat;
  int          cur_bias, cur_shift;
  bit          cur_relu;
  bit          model_en, mon_en, rnd_ready;

  function automatic logic [7:0] quant(input int psum, output bit sat);
    longint s, div, r;
    s   = longint'(psum) + longint'(cur_bias);
    div = longint'(1) << cur_shift;
    r   = s + ((cur_shift != 0) ? div / 2 : 0);
    if (r >= 0) r = r / div;
    else        r = -((-r + div - 1) / div);
    if (cur_relu && r < 0) r = 0;
    sat = 1'b0;
    if (r > 127)       begin r = 127;  sat = 1'b1; end
    else if (r < -128) begin r = -128; sat = 1'b1; end
    return r[7:0];
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_cfg(input int b, input int s, input bit r);
    cur_bias = b; cur_shift = s; cur_relu = r;
    cfg_bias = b[DATA_W-1:0]; cfg_shift = s[SHIFT_W-1:0]; cfg_relu = r;
  endtask

  task automatic send(input int d, input bit last);
    logic [7:0] q;
    bit sat;
    in_valid = 1'b1; in_data = d[DATA_W-1:0]; in_last = last;
    if (model_en) begin
      q = quant(d, sat);
      m_sat += int'(sat);
      m_word[m_lane*8 +: 8] = q;
      m_keep[m_lane] = 1'b1;
      if (m_lane == 3 || last) begin
        exp_q.push_back('{m_word, m_keep, last});
        m_word = '0; m_keep = '0; m_lane = 0;
      end else m_lane++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] ed, input logic [3:0] ek,
                           input bit el, input logic [31:0] mask);
    int n = 0;
    while (!out_valid && n < 30) begin @(posedge clk); #1; n++; end
    chk({tag, "_valid"}, out_valid, 1);
    if (out_valid) begin
      chk({tag, "_data"}, out_data & mask, ed);
      chk({tag, "_keep"}, out_keep, ek);
      chk({tag, "_last"}, out_last, el);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("sb_extra", 1, 0);
      else begin
        mon_w = exp_q.pop_front();
        chk("sb_data", out_data, mon_w.data);
        chk("sb_keep", out_keep, mon_w.keep);
        chk("sb_last", out_last, mon_w.last);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_ready) out_ready = ($urandom % 4) != 0;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] k8;
    int d, n;
    bit last;
    rst_n = 1'b0; clr_status = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    out_ready = 1'b0; model_en = 0; mon_en = 0; rnd_ready = 0;
    m_word = '0; m_keep = '0; m_lane = 0; m_sat = 0;
    set_cfg(0, 0, 0);
    wait_cycles(3);
    chk("rst_valid", out_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_sat", sat_cnt, 0);
    chk("rst_data", out_data, 0);
    chk("rst_keep", out_keep, 0);
    chk("rst_last", out_last, 0);
    rst_n = 1'b1;
    wait_cycles(2);

    // Basic quantisation and latency
    set_cfg(8, 4, 0);
    repeat (4) send(100, 0);
    wait_cycles(2);
    chk("lat_early", out_valid, 0);
    wait_cycles(1);
    chk("lat_n3", out_valid, 1);
    pop_check("q7", 32'h07070707, 4'hF, 0, 32'hFFFFFFFF);

    set_cfg(0, 0, 0);
    send(-50, 1);
    pop_check("neg", 32'hCE, 4'h1, 1, 32'hFF);
    set_cfg(0, 0, 1);
    send(-50, 1);
    pop_check("relu", 32'h00, 4'h1, 1, 32'hFF);
    chk("relu_nosat", sat_cnt, 0);

    set_cfg(0, 2, 0);
    send(5000, 1);
    pop_check("satp", 32'h7F, 4'h1, 1, 32'hFF);
    chk("satp_cnt", sat_cnt, 1);
    send(-5000, 1);
    pop_check("satn", 32'h80, 4'h1, 1, 32'hFF);
    chk("satn_cnt", sat_cnt, 2);

    // Partial row flush
    set_cfg(0, 0, 0);
    for (int i = 1; i <= 6; i++) send(i, i == 6);
    pop_check("row_w1", 32'h04030201, 4'hF, 0, 32'hFFFFFFFF);
    pop_check("row_w2", 32'h00000605, 4'h3, 1, 32'h0000FFFF);

    // Overflow: 17 words into 16 entries
    for (int k = 1; k <= 17; k++) repeat (4) send(k, 0);
    wait_cycles(6);
    chk("ovf_set", overflow, 1);
    for (int k = 1; k <= 16; k++) begin
      k8 = k[7:0];
      pop_check("drain", {4{k8}}, 4'hF, 0, 32'hFFFFFFFF);
    end
    chk("drained", out_valid, 0);
    chk("ovf_sticky", overflow, 1);
    clr_status = 1'b1;
    wait_cycles(1);
    clr_status = 1'b0;
    chk("ovf_clr", overflow, 0);

    // Push and pop on the same edge with the FIFO full
    for (int k = 1; k <= 16; k++) repeat (4) send(k, 0);
    wait_cycles(6);
    chk("full_no_ovf", overflow, 0);
    repeat (4) send(17, 0);
    wait_cycles(2);
    chk("pp_head", out_data, 32'h01010101);
    out_ready = 1'b1;
    wait_cycles(1);
    out_ready = 1'b0;
    wait_cycles(3);
    chk("pp_ovf", overflow, 0);
    for (int k = 2; k <= 17; k++) begin
      k8 = k[7:0];
      pop_check("pp_drain", {4{k8}}, 4'hF, 0, 32'hFFFFFFFF);
    end
    chk("pp_empty", out_valid, 0);

    // Reset mid-row
    for (int i = 1; i <= 4; i++) send(i, 0);
    send(9, 0);
    send(9, 0);
    wait_cycles(4);
    chk("pre_rst", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", out_valid, 0);
    chk("rst_sat2", sat_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_cycles(1);
    for (int i = 1; i <= 4; i++) send(i, 0);
    pop_check("post_rst", 32'h04030201, 4'hF, 0, 32'hFFFFFFFF);
    chk("post_rst_empty", out_valid, 0);

    // Randomized layers against the model
    model_en = 1; mon_en = 1; m_sat = 0;
    for (int layer = 0; layer < 4; layer++) begin
      set_cfg(int'($urandom) >>> 12, int'($urandom_range(0, 20)), bit'($urandom % 2));
      rnd_ready = 1;
      for (int i = 0; i < 60; i++) begin
        d = int'($urandom) >>> 7;
        if ($urandom % 2) d = int'($urandom_range(0, 2000)) - 1000;
        last = (($urandom % 5) == 0) || (i == 59);
        send(d, last);
        if (($urandom % 3) == 0) wait_cycles(1);
      end
      wait_cycles(5);
      rnd_ready = 0;
      out_ready = 1'b1;
      n = 0;
      while (exp_q.size() > 0 && n < 100) begin wait_cycles(1); n++; end
      chk("sb_drain", exp_q.size(), 0);
      out_ready = 1'b0;
      wait_cycles(1);
      chk("sb_empty", out_valid, 0);
    end
    chk("sat_model", sat_cnt, m_sat);
    chk("rnd_ovf", overflow, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
